cmd_frame_tx: RTL and testbench

CMD_FRAME_TX -- requirements
Module: cmd_frame_tx

---
 rtl/cmd_frame_tx_pkg.sv | 55 +++++
 rtl/uart_byte_ser.sv | 89 ++++++++
 rtl/cmd_frame_tx.sv | 165 ++++++++++++++++
 tb/tb_cmd_frame_tx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_tx_pkg.sv
// Shared constants and types for the command frame transmitter: frame headers,
// command-type encodings and FSM state encodings.
package cmd_frame_tx_pkg;

  localparam logic [7:0] HdrRfWr    = 8'hAA;
  localparam logic [7:0] HdrRfRd    = 8'hBB;
  localparam logic [7:0] HdrAluOp   = 8'hCC;
  localparam logic [7:0] HdrAluNoOp = 8'hDD;

  typedef enum logic [1:0] {
    CmdRfWr    = 2'd0,
    CmdRfRd    = 2'd1,
    CmdAluOp   = 2'd2,
    CmdAluNoOp = 2'd3
  } cmd_type_e;

  // Command-level sequencing: between bytes the line sits in StGap.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2
  } frame_state_e;

  // Per-byte bit sequencing inside uart_byte_ser.
  typedef enum logic [2:0] {
    StBitIdle   = 3'd0,
    StBitStart  = 3'd1,
    StBitData   = 3'd2,
    StBitParity = 3'd3,
    StBitStop   = 3'd4
  } bit_state_e;

  function automatic logic [7:0] cmd_header(input cmd_type_e t);
    logic [7:0] hdr;
    case (t)
      CmdRfWr:  hdr = HdrRfWr;
      CmdRfRd:  hdr = HdrRfRd;
      CmdAluOp: hdr = HdrAluOp;
      default:  hdr = HdrAluNoOp;
    endcase
    return hdr;
  endfunction

  function automatic logic [2:0] cmd_num_bytes(input cmd_type_e t);
    logic [2:0] n;
    case (t)
      CmdRfWr:  n = 3'd3;
      CmdRfRd:  n = 3'd2;
      CmdAluOp: n = 3'd4;
      default:  n = 3'd2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_byte_ser.sv
// Serializes one byte as start, LSB-first data, optional parity and stop bit.
// A new byte may be handed over in the cycle its predecessor's stop bit ends.
module uart_byte_ser
  import cmd_frame_tx_pkg::*;
#(
  parameter int unsigned Data_width   = 8,
  parameter int unsigned CLKS_PER_BIT = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  byte_valid_i,
  input  logic [Data_width-1:0] byte_data_i,
  input  logic                  par_en_i,
  input  logic                  par_typ_i,
  output logic                  byte_ready_o,
  output logic                  byte_done_o,
  output logic                  tx_o
);

  localparam logic [7:0] CntLoad = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] LastBit = 8'(Data_width - 1);

  bit_state_e            state_q;
  logic [7:0]            cnt_q;
  logic [7:0]            bit_idx_q;
  logic [Data_width-1:0] shift_q;
  logic                  par_q;
  logic                  par_en_q;
  logic                  tx_q;
  logic                  bit_end;

  assign bit_end      = (cnt_q == 8'd0);
  assign byte_done_o  = (state_q == StBitStop) && bit_end;
  assign byte_ready_o = (state_q == StBitIdle) || byte_done_o;
  assign tx_o         = tx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StBitIdle;
      cnt_q     <= 8'd0;
      bit_idx_q <= 8'd0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else if (byte_ready_o && byte_valid_i) begin
      state_q   <= StBitStart;
      cnt_q     <= CntLoad;
      bit_idx_q <= 8'd0;
      shift_q   <= byte_data_i;
      par_q     <= (^byte_data_i) ^ par_typ_i;
      par_en_q  <= par_en_i;
      tx_q      <= 1'b0;
    end else if (state_q != StBitIdle) begin
      if (!bit_end) begin
        cnt_q <= cnt_q - 8'd1;
      end else begin
        cnt_q <= CntLoad;
        case (state_q)
          StBitStart: begin
            state_q <= StBitData;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
          StBitData: begin
            if (bit_idx_q == LastBit) begin
              state_q <= par_en_q ? StBitParity : StBitStop;
              tx_q    <= par_en_q ? par_q : 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 8'd1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
          StBitParity: begin
            state_q <= StBitStop;
            tx_q    <= 1'b1;
          end
          default: begin
            state_q <= StBitIdle;
            cnt_q   <= 8'd0;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/cmd_frame_tx.sv
// Command frame transmitter: latches a command, expands it into header and
// payload bytes, and sends them over UART with idle gaps between bytes.
module cmd_frame_tx
  import cmd_frame_tx_pkg::*;
#(
  parameter int unsigned Data_width   = 8,
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned GAP_BITS     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_type,
  input  logic [3:0]            cmd_addr,
  input  logic [Data_width-1:0] cmd_op_a,
  input  logic [Data_width-1:0] cmd_op_b,
  input  logic [3:0]            cmd_fun,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_LINE,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned     GapW    = 12;
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_BITS * CLKS_PER_BIT - 1);

  frame_state_e          state_q;
  cmd_type_e             type_q;
  logic [3:0]            addr_q;
  logic [3:0]            fun_q;
  logic [Data_width-1:0] op_a_q;
  logic [Data_width-1:0] op_b_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [2:0]            idx_q;
  logic [GapW-1:0]       gap_cnt_q;
  logic                  done_q;

  logic                  accept;
  logic                  last_byte;
  logic                  ser_valid;
  logic                  ser_ready;
  logic                  ser_done;
  logic                  ser_par_en;
  logic                  ser_par_typ;
  logic [Data_width-1:0] ser_data;
  logic [Data_width-1:0] next_byte;
  logic [Data_width-1:0] addr_ext;
  logic [Data_width-1:0] fun_ext;

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign accept    = cmd_valid && cmd_ready && ser_ready;
  assign addr_ext  = Data_width'(addr_q);
  assign fun_ext   = Data_width'(fun_q);
  // idx_q always names the next byte to hand over; byte 0 is the header.
  assign last_byte = (idx_q == cmd_num_bytes(type_q));

  always_comb begin
    next_byte = '0;
    case (type_q)
      CmdRfWr:  next_byte = (idx_q == 3'd1) ? addr_ext : op_a_q;
      CmdRfRd:  next_byte = addr_ext;
      CmdAluOp: begin
        if (idx_q == 3'd1)      next_byte = op_a_q;
        else if (idx_q == 3'd2) next_byte = op_b_q;
        else                    next_byte = fun_ext;
      end
      default:  next_byte = fun_ext;
    endcase
  end

  // The header goes straight from the inputs so its start bit follows acceptance.
  always_comb begin
    ser_valid   = 1'b0;
    ser_data    = next_byte;
    ser_par_en  = par_en_q;
    ser_par_typ = par_typ_q;
    if (accept) begin
      ser_valid   = 1'b1;
      ser_data    = Data_width'(cmd_header(cmd_type_e'(cmd_type)));
      ser_par_en  = PAR_EN;
      ser_par_typ = PAR_TYP;
    end else if (state_q == StSend && ser_done && !last_byte && GAP_BITS == 0) begin
      ser_valid = 1'b1;
    end else if (state_q == StGap && gap_cnt_q == '0) begin
      ser_valid = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      type_q    <= CmdRfWr;
      addr_q    <= 4'd0;
      fun_q     <= 4'd0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      idx_q     <= 3'd0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            type_q    <= cmd_type_e'(cmd_type);
            addr_q    <= cmd_addr;
            fun_q     <= cmd_fun;
            op_a_q    <= cmd_op_a;
            op_b_q    <= cmd_op_b;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            idx_q     <= 3'd1;
            state_q   <= StSend;
          end
        end
        StSend: begin
          if (ser_done) begin
            if (last_byte) begin
              state_q <= StIdle;
              idx_q   <= 3'd0;
              done_q  <= 1'b1;
            end else if (GAP_BITS == 0) begin
              idx_q <= idx_q + 3'd1;
            end else begin
              state_q   <= StGap;
              gap_cnt_q <= GapLoad;
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == '0) begin
            idx_q   <= idx_q + 3'd1;
            state_q <= StSend;
          end else begin
            gap_cnt_q <= gap_cnt_q - GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  uart_byte_ser #(
    .Data_width  (Data_width),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk_i       (CLK),
    .rst_i       (RST),
    .byte_valid_i(ser_valid),
    .byte_data_i (ser_data),
    .par_en_i    (ser_par_en),
    .par_typ_i   (ser_par_typ),
    .byte_ready_o(ser_ready),
    .byte_done_o (ser_done),
    .tx_o        (TX_LINE)
  );

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Directed bench for cmd_frame_tx: a line monitor decodes UART frames and checks
// them against a scoreboard filled when each command is issued.
module tb_cmd_frame_tx;
  import cmd_frame_tx_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;
  localparam int unsigned GAP = 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_type;
  logic [3:0]    cmd_addr;
  logic [DW-1:0] cmd_op_a;
  logic [DW-1:0] cmd_op_b;
  logic [3:0]    cmd_fun;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_LINE;
  logic          busy;
  logic          done;

  typedef struct packed {
    logic [7:0] data;
    logic       par_en;
    logic       par;
  } exp_t;

  exp_t sb[$];
  int   starts[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_frames = 0;
  int   cyc = 0;
  bit   abort_req = 1'b0;

  cmd_frame_tx #(
    .Data_width  (DW),
    .CLKS_PER_BIT(CPB),
    .GAP_BITS    (GAP)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_type (cmd_type),
    .cmd_addr (cmd_addr),
    .cmd_op_a (cmd_op_a),
    .cmd_op_b (cmd_op_b),
    .cmd_fun  (cmd_fun),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .TX_LINE  (TX_LINE),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int nb, input bit pe);
    return nb * (DW + 2 + (pe ? 1 : 0)) * CPB + (nb - 1) * GAP * CPB;
  endfunction

  task automatic push_byte(input logic [7:0] b, input logic pe, input logic pt);
    exp_t e;
    e.data   = b;
    e.par_en = pe;
    e.par    = (^b) ^ pt;
    sb.push_back(e);
  endtask

  task automatic push_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] opa,
                          input logic [7:0] opb, input logic [3:0] f, input logic pe,
                          input logic pt);
    case (t)
      2'd0: begin
        push_byte(HdrRfWr, pe, pt); push_byte({4'h0, a}, pe, pt); push_byte(opa, pe, pt);
      end
      2'd1: begin
        push_byte(HdrRfRd, pe, pt); push_byte({4'h0, a}, pe, pt);
      end
      2'd2: begin
        push_byte(HdrAluOp, pe, pt); push_byte(opa, pe, pt); push_byte(opb, pe, pt);
        push_byte({4'h0, f}, pe, pt);
      end
      default: begin
        push_byte(HdrAluNoOp, pe, pt); push_byte({4'h0, f}, pe, pt);
      end
    endcase
  endtask

  // Caller sits at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] opa,
                       input logic [7:0] opb, input logic [3:0] f, input logic pe,
                       input logic pt, input bit hold, output int t_acc);
    cmd_type = t; cmd_addr = a; cmd_op_a = opa; cmd_op_b = opb; cmd_fun = f;
    PAR_EN = pe; PAR_TYP = pt; cmd_valid = 1'b1;
    push_cmd(t, a, opa, opb, f, pe, pt);
    check("ready_at_issue", cmd_ready, 1);
    @(posedge CLK);
    @(negedge CLK);
    if (!hold) cmd_valid = 1'b0;
    t_acc = cyc;
    check("start_bit_after_accept", TX_LINE, 0);
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input int limit, output int t_done);
    bit got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge CLK);
      if (done === 1'b1) got = 1'b1;
    end
    check("done_seen", got, 1);
    t_done = cyc;
  endtask

  task automatic bit_wait(inout bit ab);
    repeat (CPB) begin
      @(negedge CLK);
      if (abort_req) ab = 1'b1;
    end
  endtask

  // Line monitor: bits are sampled on negedges, one bit period apart.
  initial begin : monitor
    logic       prev;
    logic [7:0] d;
    logic       p;
    logic       s;
    bit         ab;
    bit         has;
    exp_t       e;
    prev = 1'b1;
    forever begin
      @(negedge CLK);
      if (!abort_req && RST === 1'b0 && prev === 1'b1 && TX_LINE === 1'b0) begin
        starts.push_back(cyc);
        ab  = 1'b0;
        has = (sb.size() != 0);
        e   = has ? sb[0] : '0;
        d   = '0;
        for (int i = 0; i < DW; i++) begin
          bit_wait(ab);
          d[i] = TX_LINE;
        end
        p = 1'b0;
        if (e.par_en) begin
          bit_wait(ab);
          p = TX_LINE;
        end
        bit_wait(ab);
        s = TX_LINE;
        if (!ab) begin
          n_frames++;
          check("frame_expected", has, 1);
          if (has) begin
            e = sb.pop_front();
            check("byte", d, e.data);
            if (e.par_en) check("parity", p, e.par);
            check("stop_bit", s, 1);
          end
        end
      end
      prev = TX_LINE;
    end
  end

  initial begin : stim
    int t_acc;
    int t_acc2;
    int t_done;
    int nf;
    int n_done;
    int n_low;

    RST = 1'b1; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_addr = 4'd0; cmd_op_a = '0;
    cmd_op_b = '0; cmd_fun = 4'd0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_tx", TX_LINE, 1);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // RF write, no parity: 40-cycle frames with 4-cycle gaps.
    starts.delete();
    issue(2'd0, 4'd5, 8'h3C, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, t_acc);
    wait_done(300, t_done);
    check("rfwr_latency", t_done - t_acc, 128);
    check("rfwr_latency_model", t_done - t_acc, lat(3, 1'b0));
    check("rfwr_busy_at_done", busy, 0);
    check("rfwr_nstarts", starts.size(), 3);
    if (starts.size() == 3) begin
      check("rfwr_first_start", starts[0], t_acc);
      check("rfwr_gap1", starts[1] - starts[0], 44);
      check("rfwr_gap2", starts[2] - starts[1], 44);
    end
    @(negedge CLK);
    check("rfwr_done_one_cycle", done, 0);
    check("rfwr_sb_empty", sb.size(), 0);

    // ALU with operands, even parity.
    issue(2'd2, 4'd0, 8'h12, 8'h34, 4'h2, 1'b1, 1'b0, 1'b0, t_acc);
    wait_done(400, t_done);
    check("aluop_latency", t_done - t_acc, lat(4, 1'b1));
    check("aluop_sb_empty", sb.size(), 0);
    @(negedge CLK);

    // RF read, odd parity; 0xBB has six ones so its odd-parity bit is 1.
    issue(2'd1, 4'hA, 8'h00, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0, t_acc);
    cmd_addr = 4'd3; cmd_type = 2'd0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    wait_done(300, t_done);
    check("rfrd_latency", t_done - t_acc, lat(2, 1'b1));
    check("rfrd_sb_empty", sb.size(), 0);
    @(negedge CLK);

    // Back-to-back: second command accepted in the done cycle.
    issue(2'd3, 4'd0, 8'h00, 8'h00, 4'd7, 1'b0, 1'b0, 1'b1, t_acc);
    cmd_type = 2'd0; cmd_addr = 4'd9; cmd_op_a = 8'h81; cmd_fun = 4'd0;
    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    push_cmd(2'd0, 4'd9, 8'h81, 8'h00, 4'd0, 1'b1, 1'b1);
    wait_done(300, t_done);
    check("b2b_first_latency", t_done - t_acc, lat(2, 1'b0));
    check("b2b_ready_in_done", cmd_ready, 1);
    starts.delete();
    @(negedge CLK);
    cmd_valid = 1'b0;
    t_acc2 = cyc;
    check("b2b_start_immediate", TX_LINE, 0);
    check("b2b_busy", busy, 1);
    check("b2b_start_cycle", t_acc2, t_done + 1);
    wait_done(400, t_done);
    check("b2b_second_latency", t_done - t_acc2, lat(3, 1'b1));
    check("b2b_sb_empty", sb.size(), 0);
    @(negedge CLK);

    // Reset during the data bits of byte 2.
    issue(2'd0, 4'd4, 8'hF0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, t_acc);
    repeat (54) @(negedge CLK);
    abort_req = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("abort_tx_high", TX_LINE, 1);
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    n_done = 0; n_low = 0;
    repeat (60) begin
      @(negedge CLK);
      if (done === 1'b1) n_done++;
      if (TX_LINE !== 1'b1) n_low++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_line_idle", n_low, 0);
    abort_req = 1'b0;
    sb.delete();
    @(negedge CLK);

    // cmd_valid pulsed while busy is ignored.
    nf = n_frames;
    issue(2'd1, 4'd2, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, t_acc);
    repeat (20) @(negedge CLK);
    check("busy_not_ready", cmd_ready, 0);
    cmd_type = 2'd2; cmd_op_a = 8'h99; cmd_op_b = 8'h66; cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    wait_done(300, t_done);
    check("ignore_latency", t_done - t_acc, lat(2, 1'b0));
    repeat (60) @(negedge CLK);
    check("ignore_frames", n_frames - nf, 2);
    check("ignore_idle_busy", busy, 0);
    check("ignore_idle_tx", TX_LINE, 1);
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
